mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage of the 5-stage pipelined CPU, directly downstream of the EX/MEM pipeline register.
- Consumes the M_* bundle and performs data-memory load/store.
- Resolves branch/jump redirection for the fetch stage.
- Holds the MEM/WB pipeline register that feeds write-back. Sticky error flag for misaligned stores.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of two).
- AW, 8, word-address width; log2(DEPTH).

Ports:
- CLK  in  1  pipeline clock; all state updates on falling edge, matching the other pipeline registers.
- RST  in  1  asynchronous, active-high reset.
- M_ALUout  in  32  effective address / ALU result.
- M_busB  in  32  store data.
- M_Btarg  in  32  branch target.
- M_Jtarg  in  32  jump target.
- M_Rw  in  5  destination register.
- M_Zero, M_Overflow, M_MemWr, M_Jump, M_Branch, M_MemtoReg, M_RegWr  in  1 each  EX/MEM flags and controls.
- PC_Sel  out  1  combinational: redirect fetch.
- PC_Target  out  32  combinational redirect target.
- W_Dout  out  32  registered load data.
- W_ALUout  out  32  registered ALU result.
- W_Rw  out  5  registered destination.
- W_MemtoReg, W_RegWr, W_Overflow  out  1 each  registered controls.
- Mem_Err  out  1  sticky misaligned-store flag.

Behaviour:
- Reset (async, RST=1): W_Dout, W_ALUout, W_Rw, W_MemtoReg, W_RegWr, W_Overflow and Mem_Err clear to 0 immediately, independent of CLK. Data-memory contents are not affected by RST. Memory initialises to all zeros at time 0.
- Address:
  - Word index = M_ALUout[AW+1:2].
  - Bits above AW+1 are ignored, so addresses wrap modulo DEPTH*4.
  - Misaligned means M_ALUout[1:0] != 0.
- Load:
  - Asynchronous read of mem[index].
  - Captured into W_Dout at the falling edge, giving 1 cycle latency, aligned with the other W_* fields.
  - W_Dout is captured every cycle regardless of M_MemtoReg.
  - A misaligned load reads the word at index, with the low bits ignored.
- Store (falling edge, RST=0, M_MemWr=1):
  - Aligned: mem[index] <= M_busB.
  - Misaligned: write suppressed and Mem_Err <= 1.
  - Mem_Err stays 1 until RST.
- Read-during-write: a load in the cycle after a store to the same index returns the new data. A store and load in the same M_* bundle cannot occur.
- Write-back register (falling edge):
  - W_ALUout <= M_ALUout, W_Rw <= M_Rw, W_MemtoReg <= M_MemtoReg, W_Overflow <= M_Overflow.
  - W_RegWr <= M_RegWr & ~M_Overflow: an overflowing instruction never writes the register file.
- Redirect (combinational from M_* inputs):
  - M_Jump=1: PC_Sel=1, PC_Target=M_Jtarg. Jump has priority over branch when both are set.
  - Else M_Branch & M_Zero: PC_Sel=1, PC_Target=M_Btarg.
  - Else PC_Sel=0, PC_Target=32'h0.
  - The M_* inputs come from the EX/MEM register, which resets to 0 at time 0, so PC_Sel is 0 after reset.
- Reset mid-operation:
  - An RST asserted while M_MemWr=1 blocks the write at any edge where RST=1.
  - Outputs return to 0 asynchronously.
  - The first falling edge after RST deasserts resumes normal capture.

Test Plan:
1. Reset: assert RST between edges, with W_ALUout previously 32'h1234 and Mem_Err previously 1 -> both read 0 before the next CLK edge.
2. Store/load: store M_ALUout=32'h10, M_busB=32'hDEADBEEF, then load from 32'h10 with M_MemtoReg=1 -> W_Dout=32'hDEADBEEF one falling edge after the load bundle. Load from 32'h410 (wraps to index 4, DEPTH=256) -> also DEADBEEF.
3. Misaligned store: M_MemWr=1, M_ALUout=32'h22, M_busB=32'h5 -> mem[8] unchanged and Mem_Err=1. A later aligned store leaves Mem_Err=1 until RST.
4. Overflow: M_RegWr=1, M_Overflow=1, M_Rw=5'd9 -> W_RegWr=0, W_Overflow=1, W_Rw=9.
5. Redirect:
   - M_Branch=1, M_Zero=1, M_Btarg=32'h40 -> PC_Sel=1, PC_Target=32'h40.
   - M_Zero=0 -> PC_Sel=0.
   - M_Jump=1, M_Branch=1, M_Zero=1, M_Jtarg=32'h80 -> PC_Target=32'h80.
6. Reset during store: RST=1 across a falling edge with M_MemWr=1, M_ALUout=32'h0, M_busB=32'h7 -> mem[0] retains its prior value. After deassert, a load from 32'h0 confirms this.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage: data-memory load/store, branch/jump redirect and the MEM/WB pipeline register.
// All state updates on the falling clock edge to match the neighbouring pipeline registers.
module mem_wb_stage #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_busB,
  input  logic [31:0] M_Btarg,
  input  logic [31:0] M_Jtarg,
  input  logic [4:0]  M_Rw,
  input  logic        M_Zero,
  input  logic        M_Overflow,
  input  logic        M_MemWr,
  input  logic        M_Jump,
  input  logic        M_Branch,
  input  logic        M_MemtoReg,
  input  logic        M_RegWr,
  output logic        PC_Sel,
  output logic [31:0] PC_Target,
  output logic [31:0] W_Dout,
  output logic [31:0] W_ALUout,
  output logic [4:0]  W_Rw,
  output logic        W_MemtoReg,
  output logic        W_RegWr,
  output logic        W_Overflow,
  output logic        Mem_Err
);

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic [31:0]   rd_data;
  logic          unused_addr_hi;

  // Upper address bits are ignored so accesses wrap modulo DEPTH*4.
  assign word_idx       = M_ALUout[AW+1:2];
  assign misaligned     = |M_ALUout[1:0];
  assign rd_data        = mem[word_idx];
  assign unused_addr_hi = ^M_ALUout[31:AW+2];

  // Memory contents are deliberately not cleared by RST; a write is blocked while RST is high.
  always_ff @(negedge CLK) begin
    if (!RST && M_MemWr && !misaligned) begin
      mem[word_idx] <= M_busB;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      W_Dout     <= '0;
      W_ALUout   <= '0;
      W_Rw       <= '0;
      W_MemtoReg <= 1'b0;
      W_RegWr    <= 1'b0;
      W_Overflow <= 1'b0;
      Mem_Err    <= 1'b0;
    end else begin
      W_Dout     <= rd_data;
      W_ALUout   <= M_ALUout;
      W_Rw       <= M_Rw;
      W_MemtoReg <= M_MemtoReg;
      // An overflowing instruction must never reach the register file.
      W_RegWr    <= M_RegWr & ~M_Overflow;
      W_Overflow <= M_Overflow;
      if (M_MemWr && misaligned) begin
        Mem_Err <= 1'b1;
      end
    end
  end

  // Jump wins over a taken branch.
  always_comb begin
    PC_Sel    = 1'b0;
    PC_Target = 32'h0;
    if (M_Jump) begin
      PC_Sel    = 1'b1;
      PC_Target = M_Jtarg;
    end else if (M_Branch && M_Zero) begin
      PC_Sel    = 1'b1;
      PC_Target = M_Btarg;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; expected values are hand-computed constants.
module tb_mem_wb_stage;

  logic        CLK = 1'b1;
  logic        RST;
  logic [31:0] M_ALUout, M_busB, M_Btarg, M_Jtarg;
  logic [4:0]  M_Rw;
  logic        M_Zero, M_Overflow, M_MemWr, M_Jump, M_Branch, M_MemtoReg, M_RegWr;
  logic        PC_Sel;
  logic [31:0] PC_Target, W_Dout, W_ALUout;
  logic [4:0]  W_Rw;
  logic        W_MemtoReg, W_RegWr, W_Overflow, Mem_Err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.DEPTH(256), .AW(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .M_ALUout   (M_ALUout),
    .M_busB     (M_busB),
    .M_Btarg    (M_Btarg),
    .M_Jtarg    (M_Jtarg),
    .M_Rw       (M_Rw),
    .M_Zero     (M_Zero),
    .M_Overflow (M_Overflow),
    .M_MemWr    (M_MemWr),
    .M_Jump     (M_Jump),
    .M_Branch   (M_Branch),
    .M_MemtoReg (M_MemtoReg),
    .M_RegWr    (M_RegWr),
    .PC_Sel     (PC_Sel),
    .PC_Target  (PC_Target),
    .W_Dout     (W_Dout),
    .W_ALUout   (W_ALUout),
    .W_Rw       (W_Rw),
    .W_MemtoReg (W_MemtoReg),
    .W_RegWr    (W_RegWr),
    .W_Overflow (W_Overflow),
    .Mem_Err    (Mem_Err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_bundle();
    M_ALUout = '0; M_busB = '0; M_Btarg = '0; M_Jtarg = '0; M_Rw = '0;
    M_Zero = 0; M_Overflow = 0; M_MemWr = 0; M_Jump = 0; M_Branch = 0;
    M_MemtoReg = 0; M_RegWr = 0;
  endtask

  // Advance past the next falling (active) edge and settle.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    clear_bundle();
    M_ALUout = addr; M_busB = data; M_MemWr = 1'b1;
    tick();
  endtask

  task automatic load(input logic [31:0] addr);
    clear_bundle();
    M_ALUout = addr; M_MemtoReg = 1'b1;
    tick();
  endtask

  initial begin
    clear_bundle();
    RST = 1'b1;
    #12;
    RST = 1'b0;
    #1;
    check("rst_w_dout", W_Dout, 32'h0);
    check("rst_w_aluout", W_ALUout, 32'h0);
    check("rst_w_rw", {27'h0, W_Rw}, 32'h0);
    check("rst_ctrl", {29'h0, W_MemtoReg, W_RegWr, W_Overflow}, 32'h0);
    check("rst_mem_err", {31'h0, Mem_Err}, 32'h0);
    check("rst_pc_sel", {31'h0, PC_Sel}, 32'h0);

    // Store then load, including a wrapped address
    store(32'h10, 32'hDEADBEEF);
    check("st_w_aluout", W_ALUout, 32'h10);
    load(32'h10);
    check("ld_dout", W_Dout, 32'hDEADBEEF);
    check("ld_memtoreg", {31'h0, W_MemtoReg}, 32'h1);
    load(32'h410);
    check("ld_wrap_dout", W_Dout, 32'hDEADBEEF);
    check("ld_wrap_aluout", W_ALUout, 32'h410);
    load(32'h13);
    check("ld_misaligned", W_Dout, 32'hDEADBEEF);

    // Normal register write
    clear_bundle();
    M_RegWr = 1'b1; M_Rw = 5'd3;
    tick();
    check("regwr_normal", {31'h0, W_RegWr}, 32'h1);
    check("rw_normal", {27'h0, W_Rw}, 32'd3);

    // Misaligned store is suppressed and sets a sticky error
    store(32'h20, 32'h11223344);
    check("err_after_aligned", {31'h0, Mem_Err}, 32'h0);
    store(32'h22, 32'h5);
    check("err_misaligned", {31'h0, Mem_Err}, 32'h1);
    load(32'h20);
    check("mem8_unchanged", W_Dout, 32'h11223344);
    store(32'h30, 32'h1);
    check("err_sticky", {31'h0, Mem_Err}, 32'h1);
    load(32'h30);
    check("aligned_after_err", W_Dout, 32'h1);

    // Overflow suppresses the register write
    clear_bundle();
    M_RegWr = 1'b1; M_Overflow = 1'b1; M_Rw = 5'd9;
    tick();
    check("ovf_regwr", {31'h0, W_RegWr}, 32'h0);
    check("ovf_flag", {31'h0, W_Overflow}, 32'h1);
    check("ovf_rw", {27'h0, W_Rw}, 32'd9);

    // Redirect
    clear_bundle();
    M_Branch = 1'b1; M_Zero = 1'b1; M_Btarg = 32'h40; M_Jtarg = 32'h99;
    #1;
    check("br_taken_sel", {31'h0, PC_Sel}, 32'h1);
    check("br_taken_tgt", PC_Target, 32'h40);
    M_Zero = 1'b0;
    #1;
    check("br_not_taken_sel", {31'h0, PC_Sel}, 32'h0);
    check("br_not_taken_tgt", PC_Target, 32'h0);
    M_Jump = 1'b1; M_Zero = 1'b1; M_Jtarg = 32'h80;
    #1;
    check("jmp_prio_sel", {31'h0, PC_Sel}, 32'h1);
    check("jmp_prio_tgt", PC_Target, 32'h80);
    M_Branch = 1'b0; M_Zero = 1'b0; M_Jtarg = 32'h1C0;
    #1;
    check("jmp_only_tgt", PC_Target, 32'h1C0);

    // Async reset between edges
    store(32'h0, 32'hCAFE0000);
    clear_bundle();
    M_ALUout = 32'h1234;
    tick();
    check("pre_rst_aluout", W_ALUout, 32'h1234);
    check("pre_rst_err", {31'h0, Mem_Err}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_aluout", W_ALUout, 32'h0);
    check("async_rst_err", {31'h0, Mem_Err}, 32'h0);
    check("async_rst_dout", W_Dout, 32'h0);

    // Store held off by reset across a falling edge
    clear_bundle();
    M_MemWr = 1'b1; M_ALUout = 32'h0; M_busB = 32'h7;
    tick();
    check("rst_hold_aluout", W_ALUout, 32'h0);
    #2;
    RST = 1'b0;
    load(32'h0);
    check("rst_blocked_store", W_Dout, 32'hCAFE0000);
    check("post_rst_err", {31'h0, Mem_Err}, 32'h0);
    check("post_rst_memtoreg", {31'h0, W_MemtoReg}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
